// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared types and constants for the load/store sequencer: FSM state enum,
//   RV32I load/store width codes, completion error codes, and decode helpers
//   used to classify an operation before any memory traffic is generated.
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  // Stores only have signed-agnostic b/h/w encodings; loads add bu/hu.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) bad = (f3 > F3_W);
    else          bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if
//   Data-memory port bundle between the load/store sequencer and memory.
//   master: sequencer side (drives req/we/addr/be/wdata, receives gnt/rvalid/rdata)
//   slave : memory side
// ---------------------------------------------------------------------------
interface lsu_ctrl_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align (combinational)
//   funct3     in  width/sign code of the operation
//   addr_lo    in  byte offset within the word
//   wdata      in  store source value
//   mem_rdata  in  raw word returned by memory
//   be         out byte enables for the addressed lanes
//   wdata_lane out store data replicated so every lane holds the right byte
//   rdata_ext  out selected byte/half, sign- or zero-extended (word unchanged)
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  // Replicating the data into every lane lets memory pick it up under any
  // byte-enable pattern without a shifter.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      case (funct3[1:0])
        2'b00:   wdata_lane[8*gi +: 8] = wdata[7:0];
        2'b01:   wdata_lane[8*gi +: 8] = wdata[8*(gi%2) +: 8];
        default: wdata_lane[8*gi +: 8] = wdata[8*gi +: 8];
      endcase
    end
  end

  assign byte_sel = mem_rdata[8*addr_lo +: 8];
  assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign sext     = ~funct3[2];

  always_comb begin
    case (funct3[1:0])
      2'b00:   rdata_ext = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   rdata_ext = {{16{sext & half_sel[15]}}, half_sel};
      default: rdata_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//   Load/store sequencer: takes one decoded memory op, runs the
//   request/grant/response handshake, stalls the core until done.
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, is_store, funct3,
//   addr, wdata                operation from the decoder
//   stall                      hold the core pipeline
//   done                       one-cycle completion pulse
//   rdata, err                 load result / status, held between done pulses
//   mem (lsu_ctrl_if.master)   data-memory port
// ---------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [31:0]   rdata,
  output logic [1:0]    err,
  lsu_ctrl_if.master    mem
);
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          store_reg, store_next;
  logic [2:0]    f3_reg, f3_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic [1:0]    err_reg, err_next;

  logic [3:0]    be_w;
  logic [31:0]   wlane_w;
  logic [31:0]   rext_w;
  logic          in_req;

  lsu_align u_align (
    .funct3     (f3_reg),
    .addr_lo    (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .mem_rdata  (mem.mem_rdata),
    .be         (be_w),
    .wdata_lane (wlane_w),
    .rdata_ext  (rext_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      store_reg <= 1'b0;
      f3_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= ERR_OK;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      store_reg <= store_next;
      f3_reg    <= f3_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    store_next = store_reg;
    f3_next    = f3_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          store_next = is_store;
          f3_next    = funct3;
          addr_next  = addr;
          wdata_next = wdata;
          // Classification uses the live inputs so a rejected op completes
          // one cycle after start without touching memory.
          if (f3_illegal(is_store, funct3)) begin
            state_next = ST_DONE;
            err_next   = ERR_ILL;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            state_next = ST_DONE;
            err_next   = ERR_MIS;
          end else begin
            state_next = ST_REQ;
            cnt_next   = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_gnt) begin
          cnt_next = '0;
          if (store_reg) begin
            state_next = ST_DONE;
            err_next   = ERR_OK;
          end else begin
            state_next = ST_RESP;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_DONE;
          err_next   = ERR_TMO;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (mem.mem_rvalid) begin
          rdata_next = rext_w;
          state_next = ST_DONE;
          err_next   = ERR_OK;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_DONE;
          err_next   = ERR_TMO;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus fields are gated to zero outside REQ so the port is quiet when idle.
  assign in_req        = (state_reg == ST_REQ);
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & store_reg;
  assign mem.mem_addr  = in_req ? {addr_reg[AW-1:2], 2'b00} : '0;
  assign mem.mem_be    = in_req ? be_w : 4'b0000;
  assign mem.mem_wdata = in_req ? wlane_w : 32'h0;

  assign stall = ((state_reg == ST_IDLE) & start) | in_req | (state_reg == ST_RESP);
  assign done  = (state_reg == ST_DONE);
  assign rdata = rdata_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;

  lsu_ctrl_if #(.AW(32)) mem_bus ();

  lsu_ctrl #(.TIMEOUT(TMO), .AW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .mem      (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [31:0] last_rdata = 32'h0;

  // Observations filled in by run_op
  bit          obs_done, obs_req, obs_stable, obs_stall_start, obs_stall_done, obs_req_done;
  int          obs_lat;
  logic [31:0] obs_rdata, obs_wdata, obs_addr;
  logic [1:0]  obs_err;
  logic [3:0]  obs_be;
  logic        obs_we;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
    int sz, base;
    logic [3:0] r;
    sz   = m_size(f3);
    base = int'(lo) - (int'(lo) % sz);
    r    = 4'b0;
    for (int i = 0; i < 4; i++) r[i] = (i >= base) && (i < base + sz);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2:       return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * lo);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // ---------------- driver / memory responder ----------------
  // gnt_dly: REQ cycles before granting; rv_dly: RESP cycles before rvalid (-1 = never)
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] word);
    int req_cycles, resp_cnt;
    bit pending;
    req_cycles = 0; resp_cnt = 0; pending = 0;
    obs_done = 0; obs_req = 0; obs_stable = 1; obs_lat = 0;
    obs_be = '0; obs_wdata = '0; obs_we = 0; obs_addr = '0; obs_req_done = 0;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    #1 obs_stall_start = stall;
    while (obs_lat < 200) begin
      @(negedge clk);
      obs_lat++;
      start = 1'b0;
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      if (done) begin
        obs_done       = 1;
        obs_rdata      = rdata;
        obs_err        = err;
        obs_stall_done = stall;
        obs_req_done   = mem_bus.mem_req;
        break;
      end
      if (mem_bus.mem_req) begin
        if (!obs_req) begin
          obs_req   = 1;
          obs_be    = mem_bus.mem_be;
          obs_wdata = mem_bus.mem_wdata;
          obs_we    = mem_bus.mem_we;
          obs_addr  = mem_bus.mem_addr;
        end else if (obs_be != mem_bus.mem_be || obs_wdata != mem_bus.mem_wdata ||
                     obs_we != mem_bus.mem_we || obs_addr != mem_bus.mem_addr) begin
          obs_stable = 0;
        end
        if (req_cycles == gnt_dly) begin
          mem_bus.mem_gnt = 1'b1;
          pending = !st;
        end else begin
          req_cycles++;
        end
      end else if (pending) begin
        if (rv_dly >= 0 && resp_cnt == rv_dly) begin
          mem_bus.mem_rvalid = 1'b1;
          mem_bus.mem_rdata  = word;
          pending = 0;
        end else begin
          resp_cnt++;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({stall, done, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be} !== 10'b0)
      $display("FAIL reset_ctrl: got %b expected 0", {stall, done, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be});
    else pass_cnt++;
    total_cnt++;
    if ({rdata, mem_bus.mem_addr, mem_bus.mem_wdata} !== 96'b0)
      $display("FAIL reset_data: got %h expected 0", {rdata, mem_bus.mem_addr, mem_bus.mem_wdata});
    else pass_cnt++;
    rst_n = 1'b1;
    last_rdata = 32'h0;
    $display("reset: outputs checked");
  endtask

  task automatic test_lb();
    exp_t e;
    sb_q.push_back('{32'hFFFF_FF80, ERR_OK, 3});
    run_op(1'b0, F3_B, 32'h1003, 32'h0, 0, 0, 32'h8000_0000);
    e = sb_q.pop_front();
    last_rdata = e.rdata;
    total_cnt++;
    if (obs_stall_start !== 1'b1) $display("FAIL lb_stall_start: got %b expected 1", obs_stall_start); else pass_cnt++;
    total_cnt++;
    if (obs_be !== 4'b1000 || obs_we !== 1'b0 || obs_addr !== 32'h1000)
      $display("FAIL lb_bus: got be=%b we=%b addr=%h expected be=1000 we=0 addr=00001000", obs_be, obs_we, obs_addr);
    else pass_cnt++;
    total_cnt++;
    if (!obs_done || obs_rdata !== e.rdata || obs_err !== e.err || obs_lat != e.lat)
      $display("FAIL lb_result: got done=%0b rdata=%h err=%0d lat=%0d expected rdata=%h err=%0d lat=%0d",
               obs_done, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    $display("lb  addr=00001003 rdata=%h err=%0d lat=%0d", obs_rdata, obs_err, obs_lat);
  endtask

  task automatic test_sh();
    exp_t e;
    sb_q.push_back('{last_rdata, ERR_OK, 5});
    run_op(1'b1, F3_H, 32'h2002, 32'h0000_BEEF, 3, 0, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (obs_be !== 4'b1100 || obs_we !== 1'b1 || obs_wdata !== 32'hBEEF_BEEF || obs_addr !== 32'h2000)
      $display("FAIL sh_bus: got be=%b we=%b wdata=%h addr=%h expected be=1100 we=1 wdata=beefbeef addr=00002000",
               obs_be, obs_we, obs_wdata, obs_addr);
    else pass_cnt++;
    total_cnt++;
    if (obs_stable !== 1'b1) $display("FAIL sh_stable: got %b expected 1", obs_stable); else pass_cnt++;
    total_cnt++;
    if (obs_stall_done !== 1'b0) $display("FAIL sh_stall_done: got %b expected 0", obs_stall_done); else pass_cnt++;
    total_cnt++;
    if (!obs_done || obs_rdata !== e.rdata || obs_err !== e.err || obs_lat != e.lat)
      $display("FAIL sh_result: got done=%0b rdata=%h err=%0d lat=%0d expected rdata=%h err=%0d lat=%0d",
               obs_done, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    $display("sh  addr=00002002 wdata=%h err=%0d lat=%0d", obs_wdata, obs_err, obs_lat);
  endtask

  task automatic test_misaligned();
    exp_t e;
    sb_q.push_back('{last_rdata, ERR_MIS, 1});
    run_op(1'b0, F3_W, 32'h3001, 32'h0, 0, 0, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (!obs_done || obs_req || obs_err !== e.err || obs_lat != e.lat || obs_rdata !== e.rdata)
      $display("FAIL lw_misaligned: got done=%0b req=%0b err=%0d lat=%0d rdata=%h expected req=0 err=%0d lat=%0d rdata=%h",
               obs_done, obs_req, obs_err, obs_lat, obs_rdata, e.err, e.lat, e.rdata);
    else pass_cnt++;
    $display("lw  addr=00003001 err=%0d lat=%0d", obs_err, obs_lat);

    sb_q.push_back('{last_rdata, ERR_OK, 2});
    run_op(1'b1, F3_B, 32'h3001, 32'h0000_00A5, 0, 0, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5)
      $display("FAIL sb_bus: got be=%b wdata=%h expected be=0010 wdata=a5a5a5a5", obs_be, obs_wdata);
    else pass_cnt++;
    total_cnt++;
    if (!obs_done || obs_err !== e.err || obs_lat != e.lat)
      $display("FAIL sb_result: got done=%0b err=%0d lat=%0d expected err=%0d lat=%0d", obs_done, obs_err, obs_lat, e.err, e.lat);
    else pass_cnt++;
    $display("sb  addr=00003001 be=%b err=%0d lat=%0d", obs_be, obs_err, obs_lat);
  endtask

  task automatic test_lhu_illegal();
    exp_t e;
    sb_q.push_back('{32'h0000_F00D, ERR_OK, 3});
    run_op(1'b0, F3_HU, 32'h4000, 32'h0, 0, 0, 32'h1234_F00D);
    e = sb_q.pop_front();
    last_rdata = e.rdata;
    total_cnt++;
    if (!obs_done || obs_rdata !== e.rdata || obs_err !== e.err || obs_lat != e.lat)
      $display("FAIL lhu_result: got done=%0b rdata=%h err=%0d lat=%0d expected rdata=%h err=%0d lat=%0d",
               obs_done, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    $display("lhu addr=00004000 rdata=%h err=%0d lat=%0d", obs_rdata, obs_err, obs_lat);

    sb_q.push_back('{last_rdata, ERR_ILL, 1});
    run_op(1'b0, 3'b011, 32'h4000, 32'h0, 0, 0, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (!obs_done || obs_req || obs_err !== e.err || obs_lat != e.lat || obs_rdata !== e.rdata)
      $display("FAIL ld_illegal: got done=%0b req=%0b err=%0d lat=%0d rdata=%h expected req=0 err=%0d lat=%0d rdata=%h",
               obs_done, obs_req, obs_err, obs_lat, obs_rdata, e.err, e.lat, e.rdata);
    else pass_cnt++;
    $display("ld  funct3=011 err=%0d lat=%0d", obs_err, obs_lat);

    sb_q.push_back('{last_rdata, ERR_ILL, 1});
    run_op(1'b1, F3_BU, 32'h4000, 32'h0, 0, 0, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (!obs_done || obs_req || obs_err !== e.err || obs_lat != e.lat)
      $display("FAIL st_illegal: got done=%0b req=%0b err=%0d lat=%0d expected req=0 err=%0d lat=%0d",
               obs_done, obs_req, obs_err, obs_lat, e.err, e.lat);
    else pass_cnt++;
    $display("st  funct3=100 err=%0d lat=%0d", obs_err, obs_lat);
  endtask

  task automatic test_timeout();
    exp_t e;
    // RESP timeout: grant immediately, never return data
    sb_q.push_back('{last_rdata, ERR_TMO, 2 + TMO});
    run_op(1'b0, F3_W, 32'h5000, 32'h0, 0, -1, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (!obs_done || obs_err !== e.err || obs_lat != e.lat || obs_rdata !== e.rdata)
      $display("FAIL resp_timeout: got done=%0b err=%0d lat=%0d rdata=%h expected err=%0d lat=%0d rdata=%h",
               obs_done, obs_err, obs_lat, obs_rdata, e.err, e.lat, e.rdata);
    else pass_cnt++;
    $display("lw  resp-timeout err=%0d lat=%0d", obs_err, obs_lat);
    // late response must not disturb anything
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || rdata !== last_rdata || err !== ERR_TMO)
      $display("FAIL late_rvalid: got done=%b rdata=%h err=%0d expected done=0 rdata=%h err=2", done, rdata, err, last_rdata);
    else pass_cnt++;
    $display("late rvalid: done=%b rdata=%h", done, rdata);

    // REQ timeout: never grant
    sb_q.push_back('{last_rdata, ERR_TMO, 1 + TMO});
    run_op(1'b0, F3_W, 32'h5004, 32'h0, 1000, 0, 32'h0);
    e = sb_q.pop_front();
    total_cnt++;
    if (!obs_done || obs_err !== e.err || obs_lat != e.lat || obs_req_done !== 1'b0)
      $display("FAIL req_timeout: got done=%0b err=%0d lat=%0d req=%0b expected err=%0d lat=%0d req=0",
               obs_done, obs_err, obs_lat, obs_req_done, e.err, e.lat);
    else pass_cnt++;
    $display("lw  req-timeout err=%0d lat=%0d", obs_err, obs_lat);
  endtask

  task automatic test_reset_mid_resp();
    exp_t e;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h6000;
    @(negedge clk);
    start = 1'b0;
    mem_bus.mem_gnt = mem_bus.mem_req;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    total_cnt++;
    if (stall !== 1'b1 || mem_bus.mem_req !== 1'b0)
      $display("FAIL resp_state: got stall=%b req=%b expected stall=1 req=0", stall, mem_bus.mem_req);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({stall, done, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be} !== 10'b0 || rdata !== 32'h0 ||
        mem_bus.mem_addr !== 32'h0 || mem_bus.mem_wdata !== 32'h0)
      $display("FAIL async_reset: got ctrl=%b rdata=%h expected 0", {stall, done, err, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be}, rdata);
    else pass_cnt++;
    last_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    repeat (2) begin
      total_cnt++;
      if (done !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0 || mem_bus.mem_req !== 1'b0)
        $display("FAIL stale_rvalid: got done=%b rdata=%h stall=%b req=%b expected all 0", done, rdata, stall, mem_bus.mem_req);
      else pass_cnt++;
      @(negedge clk);
    end
    $display("reset mid-RESP: rdata=%h done=%b", rdata, done);

    sb_q.push_back('{32'hCAFE_F00D, ERR_OK, 3});
    run_op(1'b0, F3_W, 32'h6004, 32'h0, 0, 0, 32'hCAFE_F00D);
    e = sb_q.pop_front();
    last_rdata = e.rdata;
    total_cnt++;
    if (!obs_done || obs_rdata !== e.rdata || obs_err !== e.err || obs_lat != e.lat)
      $display("FAIL lw_after_reset: got done=%0b rdata=%h err=%0d lat=%0d expected rdata=%h err=%0d lat=%0d",
               obs_done, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    $display("lw  addr=00006004 rdata=%h err=%0d lat=%0d", obs_rdata, obs_err, obs_lat);
  endtask

  task automatic test_back_to_back();
    logic [2:0] ld_f3 [5];
    exp_t e;
    ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    for (int n = 0; n < 12; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, wd, word, exp_rd;
      int          g, r;
      st   = 1'($urandom_range(0, 1));
      f3   = st ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      a    = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      wd   = $urandom;
      word = $urandom;
      g    = $urandom_range(0, 2);
      r    = $urandom_range(0, 2);
      exp_rd = st ? last_rdata : m_load(f3, a[1:0], word);
      sb_q.push_back('{exp_rd, ERR_OK, st ? 2 + g : 3 + g + r});
      run_op(st, f3, a, wd, g, r, word);
      e = sb_q.pop_front();
      last_rdata = e.rdata;
      total_cnt++;
      if (!obs_done || obs_rdata !== e.rdata || obs_err !== e.err || obs_lat != e.lat)
        $display("FAIL b2b_result[%0d]: got done=%0b rdata=%h err=%0d lat=%0d expected rdata=%h err=%0d lat=%0d",
                 n, obs_done, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
      else pass_cnt++;
      total_cnt++;
      if (obs_be !== m_be(f3, a[1:0]) || obs_we !== st || obs_addr !== {a[31:2], 2'b00} ||
          (st && obs_wdata !== m_wdata(f3, wd)))
        $display("FAIL b2b_bus[%0d]: got be=%b we=%b addr=%h wdata=%h expected be=%b we=%b addr=%h wdata=%h",
                 n, obs_be, obs_we, obs_addr, obs_wdata, m_be(f3, a[1:0]), st, {a[31:2], 2'b00}, m_wdata(f3, wd));
      else pass_cnt++;
      $display("b2b %0d %s f3=%03b addr=%h be=%b rdata=%h lat=%0d", n, st ? "st" : "ld", f3, a, obs_be, obs_rdata, obs_lat);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_lhu_illegal();
    test_timeout();
    test_reset_mid_resp();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the instruction decoder and the data-memory port of the RISC-V core.
- Accepts one decoded memory operation (lb/lh/lw/lbu/lhu/sb/sh/sw), runs a request/grant/response handshake with data memory, and stalls the core until completion.
- Generates byte enables and lane-aligned store data, extracts and extends load data, and reports misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16, cycles allowed in REQ or RESP before abort; minimum 2.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  core presents a memory operation this cycle.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- addr  in  AW  effective byte address.
- wdata  in  32  store source register value.
- stall  out  1  hold the core PC and pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while done=1.
- err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal funct3; valid while done=1.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  AW  word address, {addr[AW-1:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, timeout counter=0, captured operands=0. All outputs 0, including rdata, err and mem_*.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - start=1 captures is_store, funct3, addr and wdata.
  - Illegal funct3 (load 011/110/111; store >=011) -> DONE, err=3.
  - Otherwise misaligned (h with addr[0]=1; w with addr[1:0]!=0) -> DONE, err=1.
  - Otherwise -> REQ.
  - No memory request is issued for illegal or misaligned operations.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata held stable from the captured operands.
  - mem_gnt=1 with a store -> DONE, err=0.
  - mem_gnt=1 with a load -> RESP.
- RESP:
  - mem_req=0; wait for mem_rvalid.
  - On mem_rvalid, register the extracted result into rdata -> DONE, err=0.
- DONE: done=1 for exactly one cycle -> IDLE; rdata and err hold their values until the next done pulse.
- Timeout: counter cleared on entry to REQ and to RESP, incremented each cycle in those states. Reaching TIMEOUT-1 without the awaited event -> DONE, err=2, mem_req dropped.
- stall = (state==IDLE & start) | state==REQ | state==RESP. stall is 0 in DONE, so the core advances on the done cycle.
- start while not in IDLE is ignored. The core must hold start low in the cycle after done.
- mem_rvalid outside RESP is ignored; this covers stale responses after a timeout or a reset.
- Byte enables:
  - b: 4'b0001<<addr[1:0]
  - h: 4'b0011<<{addr[1],1'b0}
  - w: 4'b1111
- Store data replication:
  - b: wdata[7:0] replicated in all four lanes.
  - h: wdata[15:0] in both halves.
  - w: wdata unchanged.
- Load extraction: select the byte or half indexed by addr. Sign-extend for funct3 000/001, zero-extend for 100/101; w passes mem_rdata unchanged.
- Latency:
  - Load with immediate grant and next-cycle rvalid: done 3 cycles after start.
  - Store with immediate grant: done 2 cycles after start.
  - Misaligned or illegal: done 1 cycle after start.

Decomposition:
- Package lsu_pkg holds:
  - state enum;
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - err codes ERR_OK/ERR_MIS/ERR_TMO/ERR_ILL.
- Sub-module lsu_align (purely combinational): byte-enable generation, store replication, load extraction and extension.
- lsu_ctrl holds the FSM, operand registers and timeout counter.

Test Plan:
- lb: addr=0x1003, mem_rdata=0x80_00_00_00, gnt with req, rvalid next cycle -> mem_be=1000, rdata=0xFFFFFF80, err=0, done 3 cycles after start.
- sh: addr=0x2002, wdata=0x0000BEEF, gnt delayed 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF held stable, done 1 cycle after gnt, stall 0 in the done cycle.
- lw: addr=0x3001 -> no mem_req, done next cycle, err=1; sb at 0x3001 -> mem_be=0010, err=0.
- lhu: addr=0x4000, rdata=0x1234F00D -> rdata=0x0000F00D; load funct3=011 -> err=3 with no mem_req.
- Load: gnt given, rvalid never asserted, TIMEOUT=16 -> done with err=2 after 16 RESP cycles; a late rvalid is ignored.
- rst_n pulsed low mid-RESP -> all outputs 0 immediately; the following rvalid is ignored; the next lw completes normally.
